bk256_adder: RTL and testbench
==============================

# bk256_adder

Registered 256-bit Brent-Kung parallel-prefix adder. It computes S = A + B + Ci with carry-out Co, using a logarithmic-depth Brent-Kung carry tree. Both outputs are captured in a single output register stage. It is a datapath leaf block: upstream logic drives operands, and downstream logic samples S/Co one clock later.

## Interface
- WIDTH, 256: operand width. Fixed at 256; the Brent-Kung tree is built for a power-of-two width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  256  operand A (unsigned).
- B  input  256  operand B (unsigned).
- Ci  input  1  carry into bit 0.
- S  output  256  registered sum bits [255:0].
- Co  output  1  registered carry out of bit 255.

## Operation
- Pre-processing, per bit i:
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i]
- Ci is folded in as the carry into position 0: G[0:-1] = g[0] | (p[0] & Ci).
- Prefix operator (G,P) o (G',P') = (G | P&G', P&P').
- Up-sweep (reduction tree):
  - 8 levels; at level k, combine pairs at stride 2^k.
  - Produces group (G,P) for spans [2^(k+1)-1 : 0] at power-of-two boundaries.
- Down-sweep (distribution tree):
  - 7 levels that fill the remaining prefix positions.
  - Result: carry c[i+1] = G[i:0] for every i.
- Sum: S[i] = p[i] ^ c[i], with c[0] = Ci. Co = c[256].
- Arithmetic is unsigned, modulo 2^256; the overflow bit appears only on Co.
- No handshake: a new operand set may be applied every cycle, and each result is independent of previous ones.
- Result must be bit-exact with A + B + Ci for all inputs, including all-ones + all-ones + 1 (S = all-ones, Co = 1).

## Timing
- Latency: 1 cycle.
  - The combinational adder output is captured on the rising clk edge.
  - S/Co reflect the A/B/Ci values present just before that edge.
- Throughput: 1 result per cycle.
- Reset:
  - rst_n low forces S = 0 and Co = 0 immediately, without waiting for clk.
  - Outputs hold 0 while rst_n is low, whatever the inputs.
- Reset release:
  - The first rising edge with rst_n high loads the current sum.
  - The adder has no other state, so no recovery cycles are needed.
- Reset asserted mid-stream: the pending result is discarded and outputs go to 0 at once.
- Operands that change between edges have no effect on the outputs until the next edge.
- Critical path: about 2·log2(WIDTH) prefix cells plus the XOR stages. It must close at the project clock without retiming.

## Structure
- Shared package bk_pkg:
  - BK_WIDTH = 256
  - BK_LEVELS = 8
  - A typedef for the 256-bit operand vector.
- Sub-module bk_prefix_cell:
  - Combinational black cell with inputs gi, pi, gj, pj and outputs go = gi | pi&gj, po = pi&pj.
  - Instantiated in generate loops for the up-sweep and down-sweep.
  - Gray cells, which need G only, may reuse it with po left unconnected.
- The top contains:
  - g/p generation
  - the generate-built tree
  - the sum XOR stage
  - the async-reset output register for S and Co

## Test plan
- Reset: hold rst_n = 0 with arbitrary A/B/Ci and toggling clk -> S = 0, Co = 0 throughout.
- Full carry ripple: A = all-ones (256'hFFFF…F), B = 1, Ci = 0 -> one edge later S = 0, Co = 1.
- Small operands: A = 256'hBBBB, B = 256'h7A, Ci = 0 -> S = 256'hBC35, Co = 0.
- Reset mid-operation:
  - While the all-ones + 1 result is held, assert rst_n = 0 between clock edges -> S/Co drop to 0 immediately.
  - Deassert rst_n and apply 256'hBBBB + 256'h7A -> next edge gives 256'hBC35.
- Carry-in path and extremes:
  - A = 0, B = 0, Ci = 1 -> S = 1, Co = 0.
  - A = B = all-ones, Ci = 1 -> S = all-ones, Co = 1.
- Back-to-back random: 10k random A/B/Ci vectors, one per cycle -> each S/Co matches a reference A + B + Ci one cycle later.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared constants and types for the 256-bit Brent-Kung adder.
// Imported by the top and available to any neighbouring datapath blocks.
package bk_pkg;

   localparam int BK_WIDTH  = 256;
   localparam int BK_LEVELS = 8;

   typedef logic [BK_WIDTH-1:0] bk_vec_t;

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung black cell: combines a high (gi, pi) span with the adjacent lower (gj, pj) span.
// Gray-cell uses simply ignore po.
module bk_prefix_cell (
   input  logic gi,
   input  logic pi,
   input  logic gj,
   input  logic pj,
   output logic go,
   output logic po
);

   assign go = gi | (pi & gj);
   assign po = pi & pj;

endmodule

// File: rtl/bk256_adder.sv
// Registered 256-bit Brent-Kung adder: S/Co = A + B + Ci, captured one clock after the operands.
// Stage 0 holds per-bit (g, p); stages 1..8 are the up-sweep, stages 9..15 the down-sweep.
module bk256_adder
   import bk_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BK_WIDTH-1:0] A,
   input  logic [BK_WIDTH-1:0] B,
   input  logic                Ci,
   output logic [BK_WIDTH-1:0] S,
   output logic                Co
);

   localparam int Stages = 2 * BK_LEVELS;

   bk_vec_t g;
   bk_vec_t p;
   logic [Stages-1:0][BK_WIDTH-1:0] gt;
   logic [Stages-1:0][BK_WIDTH-1:0] pt;
   logic [BK_WIDTH:0] c;
   bk_vec_t sum_d;
   logic    carry_d;
   logic    unused_p;

   assign g = A & B;
   assign p = A ^ B;

   // Ci enters as the carry into bit 0, so every prefix G below already includes it.
   assign gt[0] = {g[BK_WIDTH-1:1], g[0] | (p[0] & Ci)};
   assign pt[0] = p;

   for (genvar k = 0; k < BK_LEVELS; k++) begin : g_up
      localparam int Span = 1 << k;
      for (genvar i = 0; i < BK_WIDTH; i++) begin : g_bit
         if (((i + 1) % (2 * Span)) == 0) begin : g_cell
            bk_prefix_cell u_cell (
               .gi (gt[k][i]),
               .pi (pt[k][i]),
               .gj (gt[k][i-Span]),
               .pj (pt[k][i-Span]),
               .go (gt[k+1][i]),
               .po (pt[k+1][i])
            );
         end else begin : g_pass
            assign gt[k+1][i] = gt[k][i];
            assign pt[k+1][i] = pt[k][i];
         end
      end
   end

   // Down-sweep: position m*2^(d+1) + 2^d - 1 picks up the full prefix ending 2^d below it.
   for (genvar j = 0; j < BK_LEVELS - 1; j++) begin : g_down
      localparam int Span = 1 << (BK_LEVELS - 2 - j);
      localparam int Src  = BK_LEVELS + j;
      for (genvar i = 0; i < BK_WIDTH; i++) begin : g_bit
         if ((((i + 1) % (2 * Span)) == Span) && (i >= 2 * Span)) begin : g_cell
            bk_prefix_cell u_cell (
               .gi (gt[Src][i]),
               .pi (pt[Src][i]),
               .gj (gt[Src][i-Span]),
               .pj (pt[Src][i-Span]),
               .go (gt[Src+1][i]),
               .po (pt[Src+1][i])
            );
         end else begin : g_pass
            assign gt[Src+1][i] = gt[Src][i];
            assign pt[Src+1][i] = pt[Src][i];
         end
      end
   end

   assign unused_p = ^pt[Stages-1];

   assign c       = {gt[Stages-1], Ci};
   assign sum_d   = p ^ c[BK_WIDTH-1:0];
   assign carry_d = c[BK_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S  <= '0;
         Co <= 1'b0;
      end else begin
         S  <= sum_d;
         Co <= carry_d;
      end
   end

endmodule

// File: tb/tb_bk256_adder.sv
// Self-checking bench for bk256_adder: directed corner cases plus 10k random vectors
// compared against plain 257-bit arithmetic.
module tb_bk256_adder;

   logic         clk;
   logic         rst_n;
   logic [255:0] a;
   logic [255:0] b;
   logic         ci;
   logic [255:0] s;
   logic         co;

   int checks;
   int errors;

   bk256_adder u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a),
      .B     (b),
      .Ci    (ci),
      .S     (s),
      .Co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [256:0] got, input logic [256:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [256:0] ref_sum(input logic [255:0] x, input logic [255:0] y,
                                            input logic cin);
      return {1'b0, x} + {1'b0, y} + {256'd0, cin};
   endfunction

   // Drive one operand set, let one rising edge pass, then compare away from the edge.
   task automatic apply_check(input string tag, input logic [255:0] x, input logic [255:0] y,
                              input logic cin);
      a  = x;
      b  = y;
      ci = cin;
      @(posedge clk);
      #1;
      check_eq(tag, {co, s}, ref_sum(x, y, cin));
   endtask

   logic [255:0] ones;
   logic [255:0] x;
   logic [255:0] y;
   logic         cin;

   initial begin
      checks = 0;
      errors = 0;
      ones   = '1;

      // Outputs stay zero while reset is held, whatever the operands.
      rst_n = 1'b0;
      a     = rand256();
      b     = rand256();
      ci    = 1'b1;
      #1;
      check_eq("reset_initial", {co, s}, 257'd0);
      for (int n = 0; n < 4; n++) begin
         a  = rand256();
         b  = rand256();
         ci = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         check_eq("reset_hold", {co, s}, 257'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      apply_check("full_ripple", ones, 256'd1, 1'b0);
      check_eq("full_ripple_lit", {co, s}, {1'b1, 256'd0});

      // Operand changes between edges must not reach the outputs.
      a = rand256();
      b = rand256();
      #2;
      check_eq("hold_between_edges", {co, s}, {1'b1, 256'd0});

      // Asynchronous reset mid-stream, well before the next rising edge.
      a     = ones;
      b     = 256'd1;
      ci    = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset", {co, s}, 257'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_check("after_reset", 256'hBBBB, 256'h7A, 1'b0);
      check_eq("after_reset_lit", {co, s}, {1'b0, 256'hBC35});

      apply_check("small", 256'hBBBB, 256'h7A, 1'b0);
      apply_check("carry_in_only", 256'd0, 256'd0, 1'b1);
      check_eq("carry_in_lit", {co, s}, 257'd1);
      apply_check("ones_ones_ci", ones, ones, 1'b1);
      check_eq("ones_ones_ci_lit", {co, s}, {1'b1, ones});
      apply_check("ones_zero_ci", ones, 256'd0, 1'b1);
      apply_check("zero", 256'd0, 256'd0, 1'b0);

      // Back-to-back random vectors, one per cycle, with occasional long-carry patterns.
      for (int n = 0; n < 10000; n++) begin
         x   = rand256();
         y   = rand256();
         cin = 1'($urandom_range(0, 1));
         case (n % 16)
            3:       y = ~x;
            7:       x = ones;
            11:      y = ones ^ (256'd1 << $urandom_range(0, 255));
            default: ;
         endcase
         apply_check("rand", x, y, cin);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
